alu_pipe_acc: RTL and testbench

ALU_PIPE_ACC -- requirements
Module: alu_pipe_acc

---
 rtl/alu_pipe_acc.sv | 90 +++++++++
 tb/tb_alu_pipe_acc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: two-stage valid/ready ALU pipeline with accumulator feedback and optional unsigned saturation
module alu_pipe_acc #(
  parameter int WIDTH = 4,
  parameter bit SAT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_use_acc,
  input  logic             in_acc_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc
);
  logic             s1_valid, s1_cin, s1_use_acc, s1_acc_we;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH-1:0] a, bb, y_raw, y;
  logic [WIDTH:0]   sum;
  logic             arith, cout, ovf, xfer;
  assign xfer = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || xfer);
  always_comb begin
    a = s1_use_acc ? acc : s1_a;
    bb = s1_op == 3'd1 ? ~s1_b : s1_b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, s1_cin};
    arith = s1_op[2:1] == 2'b00;
    y_raw = arith          ? sum[WIDTH-1:0] :
            s1_op == 3'd2  ? a & s1_b :
            s1_op == 3'd3  ? a | s1_b :
            s1_op == 3'd4  ? a ^ s1_b :
            s1_op == 3'd5  ? ~a :
            s1_op == 3'd6  ? {a[WIDTH-2:0], s1_cin} :
                             {s1_cin, a[WIDTH-1:1]};
    cout = arith         ? sum[WIDTH] :
           s1_op == 3'd6 ? a[WIDTH-1] :
           s1_op == 3'd7 ? a[0] : 1'b0;
    ovf = arith && (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // ADD clamps high on carry, SUB clamps low on borrow
    y = (SAT && arith && (s1_op[0] ^ sum[WIDTH])) ? {WIDTH{~s1_op[0]}} : y_raw;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      s1_a <= '0;
      s1_b <= '0;
      s1_cin <= 1'b0;
      s1_use_acc <= 1'b0;
      s1_acc_we <= 1'b0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_cout <= 1'b0;
      out_zero <= 1'b0;
      out_ovf <= 1'b0;
      acc <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_op <= in_op;
        s1_a <= in_a;
        s1_b <= in_b;
        s1_cin <= in_cin;
        s1_use_acc <= in_use_acc;
        s1_acc_we <= in_acc_we;
      end else if (xfer) begin
        s1_valid <= 1'b0;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_y <= y;
        out_cout <= cout;
        out_zero <= y == '0;
        out_ovf <= ovf;
        if (s1_acc_we) acc <= y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb_alu_pipe_acc: directed vectors, pipeline corner sequences and randomized scoreboard checks for alu_pipe_acc
module tb_alu_pipe_acc;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_cin = 0, in_use_acc = 0, in_acc_we = 0, out_ready = 0;
  logic [2:0] in_op = 0;
  logic [3:0] in_a = 0, in_b = 0;
  logic ir0, ir1, ov0, ov1, c0, c1, z0, z1, o0, o1;
  logic [3:0] y0, y1, acc0, acc1;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  alu_pipe_acc #(.WIDTH(4), .SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_use_acc(in_use_acc), .in_acc_we(in_acc_we),
    .out_valid(ov0), .out_ready(out_ready), .out_y(y0), .out_cout(c0), .out_zero(z0),
    .out_ovf(o0), .acc(acc0));
  alu_pipe_acc #(.WIDTH(4), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_use_acc(in_use_acc), .in_acc_we(in_acc_we),
    .out_valid(ov1), .out_ready(out_ready), .out_y(y1), .out_cout(c1), .out_zero(z1),
    .out_ovf(o1), .acc(acc1));

  typedef struct {
    int op, a, b, cin;
    bit sat;
    int y, cout, zero, ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference ALU on plain integers, returns {ovf, zero, cout, y}
  function automatic logic [6:0] model(input int op, input int a, input int b, input int cin, input bit sat);
    int s, sa, sb, ss, y, c, o;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    y = 0; c = 0; o = 0;
    case (op)
      0: begin
        s = a + b + cin; c = s > 15 ? 1 : 0; y = s % 16;
        ss = sa + sb + cin; o = (ss > 7 || ss < -8) ? 1 : 0;
        if (sat && c == 1) y = 15;
      end
      1: begin
        s = a + (15 - b) + cin; c = s > 15 ? 1 : 0; y = s % 16;
        ss = sa - sb - 1 + cin; o = (ss > 7 || ss < -8) ? 1 : 0;
        if (sat && c == 0) y = 0;
      end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 15 - a;
      6: begin y = (a * 2 + cin) % 16; c = a / 8; end
      default: begin y = cin * 8 + a / 2; c = a % 2; end
    endcase
    return {o[0], y == 0, c[0], y[3:0]};
  endfunction

  task automatic drive(input int op, input int a, input int b, input int cin, input int ua, input int we);
    in_op = op[2:0]; in_a = a[3:0]; in_b = b[3:0]; in_cin = cin[0];
    in_use_acc = ua[0]; in_acc_we = we[0];
  endtask

  task automatic single(input int op, input int a, input int b, input int cin, input int ua, input int we,
                        output logic [6:0] r0, output logic [6:0] r1, output int lat);
    @(negedge clk);
    out_ready = 1; in_valid = 1; drive(op, a, b, cin, ua, we);
    #1 check("single_in_ready", ir0, 1);
    @(negedge clk);
    in_valid = 0; lat = 1;
    while (!ov0 && lat < 10) begin @(negedge clk); lat++; end
    r0 = {o0, z0, c0, y0};
    r1 = {o1, z1, c1, y1};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    check("reset_in_ready", ir0, 0);
    @(negedge clk);
    rst = 0;
  endtask

  vec_t vecs[12];
  logic [6:0] r0, r1, e;
  int lat, accepted, nxt, hold;
  int got[$];
  logic [6:0] q0[$], q1[$];
  int macc0, macc1;

  initial begin
    vecs[0]  = '{0, 7, 1, 0, 0, 8, 0, 0, 1};
    vecs[1]  = '{0, 15, 2, 0, 1, 15, 1, 0, 0};
    vecs[2]  = '{1, 1, 3, 1, 1, 0, 0, 1, 0};
    vecs[3]  = '{6, 9, 0, 1, 0, 3, 1, 0, 0};
    vecs[4]  = '{7, 9, 0, 0, 0, 4, 1, 0, 0};
    vecs[5]  = '{4, 5, 5, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{2, 12, 10, 0, 0, 8, 0, 0, 0};
    vecs[7]  = '{3, 12, 10, 0, 0, 14, 0, 0, 0};
    vecs[8]  = '{5, 5, 0, 0, 0, 10, 0, 0, 0};
    vecs[9]  = '{1, 8, 1, 1, 0, 7, 1, 0, 1};
    vecs[10] = '{1, 1, 3, 1, 0, 14, 0, 0, 0};
    vecs[11] = '{0, 15, 1, 0, 0, 0, 1, 1, 0};

    repeat (2) @(negedge clk);
    check("rst_in_ready", ir0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_acc", acc0, 0);
    check("rst_out_y", y0, 0);
    check("rst_flags", {c0, z0, o0}, 0);
    rst = 0;

    for (int i = 0; i < 12; i++) begin
      single(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 0, 0, r0, r1, lat);
      if (vecs[i].sat) r0 = r1;
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_y", i), r0[3:0], vecs[i].y);
      check($sformatf("vec%0d_cout", i), r0[4], vecs[i].cout);
      check($sformatf("vec%0d_zero", i), r0[5], vecs[i].zero);
      check($sformatf("vec%0d_ovf", i), r0[6], vecs[i].ovf);
    end

    // back-to-back accumulate
    do_reset();
    got.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1; in_valid = c < 4; drive(0, 0, 3, 0, 1, 1);
      #1;
      if (c < 4) check("acc_chain_in_ready", ir0, 1);
      if (ov0) got.push_back(int'(y0));
    end
    check("acc_chain_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("acc_chain_y", got[i], 3 * (i + 1));
    check("acc_chain_acc", acc0, 12);

    // backpressure: two stages fill then stall
    accepted = 0; nxt = 1; hold = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 0; in_valid = 1; drive(0, nxt, 0, 0, 0, 0);
      #1;
      if (ov0 && hold < 0) hold = y0;
      if (ir0) begin accepted++; nxt++; end
    end
    check("bp_accepted", accepted, 2);
    check("bp_in_ready", ir0, 0);
    check("bp_out_y_stable", y0, hold);
    got.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 0; out_ready = 1;
      #1 if (ov0) got.push_back(int'(y0));
    end
    check("bp_drain_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_order0", got[0], 1);
      check("bp_order1", got[1], 2);
    end
    single(0, 4, 5, 0, 0, 0, r0, r1, lat);
    check("bp_resume_y", r0[3:0], 9);

    // reset while full with acc=6
    do_reset();
    single(0, 0, 6, 0, 1, 1, r0, r1, lat);
    check("rf_acc6", acc0, 6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 0; in_valid = 1; drive(0, 3, 3, 0, 0, 1);
    end
    #1 check("rf_full_in_ready", ir0, 0);
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    check("rf_out_valid", ov0, 0);
    check("rf_acc", acc0, 0);
    check("rf_in_ready", ir0, 0);
    rst = 0;
    single(0, 1, 1, 0, 0, 0, r0, r1, lat);
    check("rf_after_y", r0[3:0], 2);

    // randomized run against the model
    do_reset();
    macc0 = 0; macc1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < (c < 390 ? 6 : 10);
      drive($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if (c >= 390) in_valid = 0;
      #1;
      if (ov0 && out_ready) begin
        e = q0.size() ? q0.pop_front() : 7'h7f;
        check("rand_sat0", {o0, z0, c0, y0}, e);
      end
      if (ov1 && out_ready) begin
        e = q1.size() ? q1.pop_front() : 7'h7f;
        check("rand_sat1", {o1, z1, c1, y1}, e);
      end
      if (in_valid && ir0) begin
        e = model(in_op, in_use_acc ? macc0 : in_a, in_b, in_cin, 0);
        q0.push_back(e);
        if (in_acc_we) macc0 = e[3:0];
        e = model(in_op, in_use_acc ? macc1 : in_a, in_b, in_cin, 1);
        q1.push_back(e);
        if (in_acc_we) macc1 = e[3:0];
      end
    end
    check("rand_q0_empty", q0.size(), 0);
    check("rand_q1_empty", q1.size(), 0);
    check("rand_acc0", acc0, macc0);
    check("rand_acc1", acc1, macc1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
